// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a write-pending scoreboard.
//
// Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. There are two combinational
// read ports and one write port that updates on the rising clock edge.
// Per register, a busy bit records that a write has been issued upstream but
// has not yet landed, so the decode stage can detect read-after-write hazards.
//
// Ports:
//   CLK          clock; all state updates on posedge
//   RESET        asynchronous active-high reset; clears data, busy bits and count
//   WRITEDATA    data to write
//   WRITEREG     write address
//   WRITEENABLE  write strobe
//   READREG1/2   read addresses
//   REGOUT1/2    read data (combinational; forwarded from WRITEDATA when BYPASS)
//   BUSYSET      mark BUSYREG as pending
//   BUSYREG      register to mark pending
//   BUSY1/2      pending-write flag for READREG1/2 (combinational)
//   BUSYCOUNT    registered population count of the busy vector
//
// Parameters:
//   BYPASS   1'b1: a same-cycle write is forwarded to the read ports and clears BUSYn
//   ZERO_REG 1'b1: register 0 reads as zero and ignores writes and busy-set
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  input  logic [ADDR_WIDTH-1:0] WRITEREG,
  input  logic                  WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [ADDR_WIDTH-1:0] READREG2,
  output logic [DATA_WIDTH-1:0] REGOUT1,
  output logic [DATA_WIDTH-1:0] REGOUT2,
  input  logic                  BUSYSET,
  input  logic [ADDR_WIDTH-1:0] BUSYREG,
  output logic                  BUSY1,
  output logic                  BUSY2,
  output logic [ADDR_WIDTH:0]   BUSYCOUNT
);

  localparam int N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [N];
  logic [N-1:0]          busy_r;
  logic [N-1:0]          busy_next_s;
  logic [ADDR_WIDTH:0]   busy_count_r;

  logic                  write_ok_s;
  logic                  set_ok_s;
  logic                  fwd1_s;
  logic                  fwd2_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;
  logic                  busy1_s;
  logic                  busy2_s;

  // Number of set bits; sized so that an all-busy vector (N) fits without wrapping.
  function automatic logic [ADDR_WIDTH:0] popcount(input logic [N-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = {(ADDR_WIDTH+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Qualify write and busy-set strobes: both are ignored during reset and,
  // with ZERO_REG, whenever they target register 0.
  always_comb begin
    write_ok_s = 1'b0;
    set_ok_s   = 1'b0;
    if (RESET) begin
      write_ok_s = 1'b0;
      set_ok_s   = 1'b0;
    end else begin
      write_ok_s = WRITEENABLE & ~(ZERO_REG & (WRITEREG == ZERO_ADDR));
      set_ok_s   = BUSYSET     & ~(ZERO_REG & (BUSYREG  == ZERO_ADDR));
    end
  end

  // Next busy vector: the write clears first, then the set is applied so that
  // a new producer issued on the same edge keeps the register pending.
  always_comb begin
    busy_next_s = busy_r;
    if (write_ok_s) begin
      busy_next_s[WRITEREG] = 1'b0;
    end else begin
      busy_next_s[WRITEREG] = busy_r[WRITEREG];
    end
    if (set_ok_s) begin
      busy_next_s[BUSYREG] = 1'b1;
    end else begin
      busy_next_s[BUSYREG] = busy_next_s[BUSYREG];
    end
  end

  // Read ports: array read, optional forwarding of the in-flight write, zero-register override.
  always_comb begin
    fwd1_s  = BYPASS & write_ok_s & (WRITEREG == READREG1);
    fwd2_s  = BYPASS & write_ok_s & (WRITEREG == READREG2);
    rd1_s   = regs_r[READREG1];
    rd2_s   = regs_r[READREG2];
    busy1_s = busy_r[READREG1];
    busy2_s = busy_r[READREG2];
    // A forwarded value is valid this cycle, so the hazard flag drops even if
    // the same register is re-marked busy on the coming edge.
    if (fwd1_s) begin
      rd1_s   = WRITEDATA;
      busy1_s = 1'b0;
    end else begin
      rd1_s   = regs_r[READREG1];
      busy1_s = busy_r[READREG1];
    end
    if (fwd2_s) begin
      rd2_s   = WRITEDATA;
      busy2_s = 1'b0;
    end else begin
      rd2_s   = regs_r[READREG2];
      busy2_s = busy_r[READREG2];
    end
    if (ZERO_REG && (READREG1 == ZERO_ADDR)) begin
      rd1_s   = ZERO_DATA;
      busy1_s = 1'b0;
    end else begin
      rd1_s   = rd1_s;
      busy1_s = busy1_s;
    end
    if (ZERO_REG && (READREG2 == ZERO_ADDR)) begin
      rd2_s   = ZERO_DATA;
      busy2_s = 1'b0;
    end else begin
      rd2_s   = rd2_s;
      busy2_s = busy2_s;
    end
  end

  // State update: register array, busy vector and its registered count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
      busy_r       <= {N{1'b0}};
      busy_count_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (write_ok_s) begin
        regs_r[WRITEREG] <= WRITEDATA;
      end
      busy_r       <= busy_next_s;
      busy_count_r <= popcount(busy_next_s);
    end
  end

  assign REGOUT1   = rd1_s;
  assign REGOUT2   = rd2_s;
  assign BUSY1     = busy1_s;
  assign BUSY2     = busy2_s;
  assign BUSYCOUNT = busy_count_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Two instances share the stimulus:
//   dut_a: BYPASS=1, ZERO_REG=0 (defaults)
//   dut_b: BYPASS=0, ZERO_REG=1
// A vector table covers write/read, scoreboard lifecycle, simultaneous
// set/write, zero register and count saturation; hand-written sequences
// cover asynchronous reset and reset-with-write.
module tb_reg_file_sb;

  logic       clk;
  logic       rst;
  logic [7:0] wd;
  logic [2:0] wreg;
  logic       we;
  logic [2:0] r1;
  logic [2:0] r2;
  logic       bs;
  logic [2:0] breg;

  logic [7:0] a_o1, a_o2, b_o1, b_o2;
  logic       a_b1, a_b2, b_b1, b_b2;
  logic [3:0] a_cnt, b_cnt;

  int n_checks;
  int n_fail;

  reg_file_sb dut_a (
    .CLK(clk), .RESET(rst), .WRITEDATA(wd), .WRITEREG(wreg), .WRITEENABLE(we),
    .READREG1(r1), .READREG2(r2), .REGOUT1(a_o1), .REGOUT2(a_o2),
    .BUSYSET(bs), .BUSYREG(breg), .BUSY1(a_b1), .BUSY2(a_b2), .BUSYCOUNT(a_cnt)
  );

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .CLK(clk), .RESET(rst), .WRITEDATA(wd), .WRITEREG(wreg), .WRITEENABLE(we),
    .READREG1(r1), .READREG2(r2), .REGOUT1(b_o1), .REGOUT2(b_o2),
    .BUSYSET(bs), .BUSYREG(breg), .BUSY1(b_b1), .BUSY2(b_b2), .BUSYCOUNT(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wreg;
    logic [7:0] wd;
    logic       bs;
    logic [2:0] breg;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] ao1;
    logic [7:0] ao2;
    logic       ab1;
    logic       ab2;
    logic [3:0] acnt;
    logic [7:0] bo1;
    logic [7:0] bo2;
    logic       bb1;
    logic       bb2;
    logic [3:0] bcnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input int ao1, input int ao2, input int ab1, input int ab2, input int acnt,
                         input int bo1, input int bo2, input int bb1, input int bb2, input int bcnt);
    chk({tag, " a.regout1"}, int'(a_o1), ao1);
    chk({tag, " a.regout2"}, int'(a_o2), ao2);
    chk({tag, " a.busy1"},   int'(a_b1), ab1);
    chk({tag, " a.busy2"},   int'(a_b2), ab2);
    chk({tag, " a.busycnt"}, int'(a_cnt), acnt);
    chk({tag, " b.regout1"}, int'(b_o1), bo1);
    chk({tag, " b.regout2"}, int'(b_o2), bo2);
    chk({tag, " b.busy1"},   int'(b_b1), bb1);
    chk({tag, " b.busy2"},   int'(b_b2), bb2);
    chk({tag, " b.busycnt"}, int'(b_cnt), bcnt);
  endtask

  task automatic drive(input logic we_i, input logic [2:0] wreg_i, input logic [7:0] wd_i,
                       input logic bs_i, input logic [2:0] breg_i,
                       input logic [2:0] r1_i, input logic [2:0] r2_i);
    we = we_i; wreg = wreg_i; wd = wd_i; bs = bs_i; breg = breg_i; r1 = r1_i; r2 = r2_i;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            we wreg wd   bs breg r1 r2 | ao1 ao2 ab1 ab2 acnt | bo1 bo2 bb1 bb2 bcnt
    vecs[0]  = '{1'b1, 3'd2, 8'd76, 1'b0, 3'd0, 3'd2, 3'd1, 8'd76, 8'd0,  1'b0, 1'b0, 4'd0, 8'd0,  8'd0,  1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 3'd1, 8'd28, 1'b0, 3'd0, 3'd2, 3'd1, 8'd76, 8'd28, 1'b0, 1'b0, 4'd0, 8'd76, 8'd0,  1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd2, 3'd1, 8'd76, 8'd28, 1'b0, 1'b0, 4'd0, 8'd76, 8'd28, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd4, 3'd4, 3'd1, 8'd0,  8'd28, 1'b0, 1'b0, 4'd0, 8'd0,  8'd28, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 3'd4, 8'd6,  1'b0, 3'd0, 3'd4, 3'd3, 8'd6,  8'd0,  1'b0, 1'b0, 4'd1, 8'd0,  8'd0,  1'b1, 1'b0, 4'd1};
    vecs[5]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd3, 3'd4, 3'd3, 8'd6,  8'd0,  1'b0, 1'b0, 4'd0, 8'd6,  8'd0,  1'b0, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 3'd3, 8'd35, 1'b1, 3'd3, 3'd4, 3'd3, 8'd6,  8'd35, 1'b0, 1'b0, 4'd1, 8'd6,  8'd0,  1'b0, 1'b1, 4'd1};
    vecs[7]  = '{1'b1, 3'd3, 8'd36, 1'b1, 3'd5, 3'd5, 3'd3, 8'd0,  8'd36, 1'b0, 1'b0, 4'd1, 8'd0,  8'd35, 1'b0, 1'b1, 4'd1};
    vecs[8]  = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd5, 3'd3, 8'd0,  8'd36, 1'b1, 1'b0, 4'd1, 8'd0,  8'd36, 1'b1, 1'b0, 4'd1};
    vecs[9]  = '{1'b1, 3'd0, 8'd50, 1'b1, 3'd0, 3'd0, 3'd5, 8'd50, 8'd0,  1'b0, 1'b1, 4'd1, 8'd0,  8'd0,  1'b0, 1'b1, 4'd1};
    vecs[10] = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd0, 3'd5, 8'd50, 8'd0,  1'b1, 1'b1, 4'd2, 8'd0,  8'd0,  1'b0, 1'b1, 4'd1};
    vecs[11] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd1, 3'd1, 3'd2, 8'd28, 8'd76, 1'b0, 1'b0, 4'd2, 8'd28, 8'd76, 1'b0, 1'b0, 4'd1};
    vecs[12] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd2, 3'd1, 3'd2, 8'd28, 8'd76, 1'b1, 1'b0, 4'd3, 8'd28, 8'd76, 1'b1, 1'b0, 4'd2};
    vecs[13] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd4, 3'd6, 3'd7, 8'd0,  8'd0,  1'b0, 1'b0, 4'd4, 8'd0,  8'd0,  1'b0, 1'b0, 4'd3};
    vecs[14] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd6, 3'd6, 3'd7, 8'd0,  8'd0,  1'b0, 1'b0, 4'd5, 8'd0,  8'd0,  1'b0, 1'b0, 4'd4};
    vecs[15] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd7, 3'd6, 3'd7, 8'd0,  8'd0,  1'b1, 1'b0, 4'd6, 8'd0,  8'd0,  1'b1, 1'b0, 4'd5};
    vecs[16] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd3, 3'd6, 3'd7, 8'd0,  8'd0,  1'b1, 1'b1, 4'd7, 8'd0,  8'd0,  1'b1, 1'b1, 4'd6};
    vecs[17] = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd5, 3'd3, 3'd0, 8'd36, 8'd50, 1'b1, 1'b1, 4'd8, 8'd36, 8'd0,  1'b1, 1'b0, 4'd7};
    vecs[18] = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 3'd3, 3'd0, 8'd36, 8'd50, 1'b1, 1'b1, 4'd8, 8'd36, 8'd0,  1'b1, 1'b0, 4'd7};

    // Reset asserted from time zero; outputs must be clear before any clock edge.
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd7);
    #2;
    chk_all("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: inputs applied just after an edge, outputs sampled on the negedge.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wd, vecs[i].bs, vecs[i].breg, vecs[i].r1, vecs[i].r2);
      @(negedge clk);
      chk_all($sformatf("v%0d", i),
              int'(vecs[i].ao1), int'(vecs[i].ao2), int'(vecs[i].ab1), int'(vecs[i].ab2), int'(vecs[i].acnt),
              int'(vecs[i].bo1), int'(vecs[i].bo2), int'(vecs[i].bb1), int'(vecs[i].bb2), int'(vecs[i].bcnt));
      @(posedge clk); #1;
    end

    // Mid-cycle reset with everything busy: must clear without a clock edge.
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd3, 3'd0);
    rst = 1'b1;
    #2;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write and busy-set presented across an edge while reset is high are ignored,
    // and not forwarded either.
    drive(1'b1, 3'd3, 8'd99, 1'b1, 3'd3, 3'd3, 3'd0);
    #1;
    chk_all("rst_wr_pre", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd3, 3'd0);
    rst = 1'b0;
    #2;
    chk_all("rst_wr_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // First write after release lands on the next edge; only dut_a forwards it.
    @(posedge clk); #1;
    drive(1'b1, 3'd3, 8'd5, 1'b0, 3'd0, 3'd3, 3'd0);
    @(negedge clk);
    chk_all("post_rst_fwd", 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd3, 3'd0);
    @(negedge clk);
    chk_all("post_rst_rd", 5, 0, 0, 0, 0, 5, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the lab 8x8 register file, for the pipelined simple processor.
- Provides N = 2**ADDR_WIDTH registers of DATA_WIDTH bits, two asynchronous read ports and one synchronous write port.
- Adds an optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard so the decode stage can detect read-after-write hazards against in-flight writes.

Parameters:
DATA_WIDTH, 8, register width in bits
ADDR_WIDTH, 3, register address width; depth N = 2**ADDR_WIDTH
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and busy-set; 0 = register 0 is ordinary

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  asynchronous, active-high reset
WRITEDATA  input  DATA_WIDTH  data to write
WRITEREG  input  ADDR_WIDTH  write address
WRITEENABLE  input  1  write strobe, sampled at posedge CLK
READREG1  input  ADDR_WIDTH  read port 1 address
READREG2  input  ADDR_WIDTH  read port 2 address
REGOUT1  output  DATA_WIDTH  read port 1 data
REGOUT2  output  DATA_WIDTH  read port 2 data
BUSYSET  input  1  mark BUSYREG pending (write issued upstream), sampled at posedge CLK
BUSYREG  input  ADDR_WIDTH  register to mark pending
BUSY1  output  1  READREG1 has a pending write
BUSY2  output  1  READREG2 has a pending write
BUSYCOUNT  output  ADDR_WIDTH+1  number of registers currently marked busy

Behaviour:
Reset:
- RESET high asynchronously clears all registers to 0, all busy bits to 0 and BUSYCOUNT to 0, independent of CLK.
- While RESET is high, writes and BUSYSET are ignored.
- The first update after release happens on the first posedge with RESET low.

Write:
- At posedge CLK with WRITEENABLE=1: reg[WRITEREG] <= WRITEDATA. Single-cycle latency.
- ZERO_REG=1 and WRITEREG=0: the write is dropped.

Read:
- Combinational from the array: REGOUTn = reg[READREGn].
- BYPASS=1, WRITEENABLE=1, WRITEREG==READREGn (and not the zero register): REGOUTn = WRITEDATA in the same cycle.
- ZERO_REG=1 and READREGn=0: REGOUTn = 0 always.

Scoreboard:
- Posedge with BUSYSET=1: busy[BUSYREG] <= 1.
- Posedge with WRITEENABLE=1: busy[WRITEREG] <= 0.
- Same edge, BUSYSET and WRITEENABLE to the same register: set wins, busy stays/becomes 1 (a new producer was issued).
- Same edge, different registers: both take effect.
- BUSYSET on an already-busy register: no change, no count change.
- A write to a non-busy register leaves busy at 0.
- ZERO_REG=1: busy[0] is never set.

Busy outputs:
- BUSYn = busy[READREGn], combinational.
- BYPASS=1 with a same-cycle write to READREGn: BUSYn = 0, because the data is forwarded. This holds even if BUSYSET targets the same register on that edge, since the current forwarded value is valid this cycle.
- BUSYCOUNT equals the population count of the busy vector after each edge; registered, 0..N, never wraps.

Test Plan:
1. Reset and read: RESET pulse mid-cycle, then READREG1=0, READREG2=7 -> REGOUT1=REGOUT2=0, BUSY1=BUSY2=0, BUSYCOUNT=0 immediately on RESET rise, without waiting for CLK.
2. Write then read: write 76 to r2, then 28 to r1; READREG1=2, READREG2=1 -> 76 and 28 after each edge. With BYPASS=1, REGOUT shows 28 in the cycle WRITEENABLE is high; with BYPASS=0, only after the edge.
3. Scoreboard lifecycle: BUSYSET r4 -> BUSY1=1 (READREG1=4), BUSYCOUNT=1. Write 6 to r4 -> BUSY1=0, count 0, REGOUT1=6.
4. Simultaneous events: busy r3 set; same edge BUSYSET r3 + write 35 to r3 -> r3=35, busy[3]=1, count unchanged. Same edge BUSYSET r5 + write r3 -> busy[5]=1, busy[3]=0.
5. Zero register: ZERO_REG=1; write 50 to r0 and BUSYSET r0 -> REGOUT=0, BUSY=0, count 0. With ZERO_REG=0 the same stimulus reads 50 after the edge and busy is set.
6. Count bounds and mid-operation reset: set busy on all 8 registers -> BUSYCOUNT=8. Assert RESET between edges -> count 0, all data 0; a write on the same edge as RESET high is ignored.
